// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that shares one 32x32 multiplier among NUM_REQ requesters.
// One multiplication in flight; the result returns on a shared, id-tagged response channel.
module mult_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [63:0]             rsp_product,
  input  logic                    rsp_ready,
  output logic                    mult_start,
  output logic [31:0]             mult_a,
  output logic [31:0]             mult_b,
  input  logic                    mult_busy,
  input  logic [63:0]             mult_product,
  output logic                    arb_busy
);

  localparam int unsigned OP_W   = 32;
  localparam int unsigned PROD_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ARM,
    ST_RUN,
    ST_RESP
  } state_e;

  state_e              state_q;
  logic [ID_W-1:0]     last_grant_q;
  logic [ID_W-1:0]     cur_id_q;
  logic [OP_W-1:0]     op_a_q;
  logic [OP_W-1:0]     op_b_q;
  logic                mult_start_q;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [PROD_W-1:0]   rsp_product_q;
  logic                arb_busy_q;

  logic [OP_W-1:0]     a_arr [NUM_REQ];
  logic [OP_W-1:0]     b_arr [NUM_REQ];
  logic                grant_found;
  logic [ID_W-1:0]     grant_id;
  logic [ID_W-1:0]     cand_id;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*OP_W +: OP_W];
    assign b_arr[i] = req_b[i*OP_W +: OP_W];
  end

  // Rotating scan from last_grant+1; walking offsets downward lets the nearest requester win.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand_id     = '0;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      cand_id = ID_W'((int'(last_grant_q) + k) % int'(NUM_REQ));
      if (req_valid[cand_id]) begin
        grant_found = 1'b1;
        grant_id    = cand_id;
      end
    end
  end

  // Accept is only offered in IDLE so the requester sees the handshake in the grant cycle.
  assign req_ready = (state_q == ST_IDLE && grant_found && !reset)
                     ? (NUM_REQ'(1) << grant_id) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= ID_W'(NUM_REQ - 1);
      cur_id_q      <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      mult_start_q  <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
      arb_busy_q    <= 1'b0;
    end else begin
      mult_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_found) begin
            op_a_q       <= a_arr[grant_id];
            op_b_q       <= b_arr[grant_id];
            cur_id_q     <= grant_id;
            last_grant_q <= grant_id;
            mult_start_q <= 1'b1;
            arb_busy_q   <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_q <= ST_ARM;
        // ARM absorbs the multiplier's start-to-busy latency.
        ST_ARM:   state_q <= ST_RUN;
        ST_RUN: begin
          if (!mult_busy) begin
            rsp_product_q <= mult_product;
            rsp_id_q      <= cur_id_q;
            rsp_valid_q   <= 1'b1;
            state_q       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            arb_busy_q  <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          arb_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign mult_start  = mult_start_q;
  assign mult_a      = op_a_q;
  assign mult_b      = op_b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;
  assign arb_busy    = arb_busy_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: behavioural multiplier with programmable busy time,
// response scoreboard plus per-scenario timing and ordering checks.
module tb_mult_share_arbiter;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    req_valid = '0;
  logic [127:0]  req_a = '0;
  logic [127:0]  req_b = '0;
  logic [3:0]    req_ready;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [63:0]   rsp_product;
  logic          rsp_ready = 1'b1;
  logic          mult_start;
  logic [31:0]   mult_a;
  logic [31:0]   mult_b;
  logic          mult_busy;
  logic [63:0]   mult_product;
  logic          arb_busy;

  mult_share_arbiter #(.NUM_REQ(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product), .rsp_ready(rsp_ready),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_busy(mult_busy), .mult_product(mult_product), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: busy for mult_lat cycles starting the cycle after start.
  int          mult_lat = 3;
  int          m_cnt;
  logic [31:0] m_a, m_b;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt <= 0; mult_busy <= 1'b0; mult_product <= '0; m_a <= '0; m_b <= '0;
    end else if (mult_start) begin
      m_cnt <= mult_lat; mult_busy <= 1'b1; m_a <= mult_a; m_b <= mult_b;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        mult_busy    <= 1'b0;
        mult_product <= 64'(m_a) * 64'(m_b);
      end
    end
  end

  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] prod;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic sb_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid && rsp_ready) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got id=%0d prod=%h, required no response", rsp_id, rsp_product);
        end else begin
          e = sb_q.pop_front();
          if ({rsp_id, rsp_product} !== {e.id, e.prod}) begin
            n_fail++;
            $display("FAIL sb_response: got id=%0d prod=%h, required id=%0d prod=%h",
                     rsp_id, rsp_product, e.id, e.prod);
          end
        end
      end
    end
  endtask

  task automatic set_req(input logic [1:0] id, input logic [31:0] a, input logic [31:0] b);
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.id   = id;
    e.prod = 64'(a) * 64'(b);
    sb_q.push_back(e);
  endtask

  // Drives one request alone and reports accept / start / response cycle numbers (-1 if unseen).
  task automatic issue(input logic [1:0] id, input logic [31:0] a, input logic [31:0] b,
                       input int lat, output int t_acc, output int t_start, output int t_rsp);
    t_acc = -1; t_start = -1; t_rsp = -1;
    @(posedge clk); #1;
    set_req(id, a, b);
    mult_lat = lat;
    req_valid[id] = 1'b1;
    push_exp(id, a, b);
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready[id]) begin t_acc = cyc; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (mult_start && t_start < 0) t_start = cyc;
      if (rsp_valid) begin t_rsp = cyc; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #2;
      if (!arb_busy && !rsp_valid) break;
    end
    n_tests++;
    if (arb_busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: got arb_busy=%b rsp_valid=%b, required 0 0", name, arb_busy, rsp_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if ({req_ready, rsp_valid, rsp_id, mult_start, arb_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy=%b vld=%b id=%0d start=%b busy=%b, required all 0",
               req_ready, rsp_valid, rsp_id, mult_start, arb_busy);
    end
    n_tests++;
    if ({rsp_product, mult_a, mult_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got prod=%h a=%h b=%h, required 0", rsp_product, mult_a, mult_b);
    end
    req_valid = 4'hF; #1;
    n_tests++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, required 0000", req_ready);
    end
    req_valid = '0;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_single();
    int ta, ts, tr;
    issue(2'd0, 32'h0000_00FF, 32'h0000_FFFF, 3, ta, ts, tr);
    n_tests++;
    if (ta < 0) begin n_fail++; $display("FAIL single_accept: got none, required req_ready[0]"); end
    n_tests++;
    if (ts != ta + 1) begin n_fail++; $display("FAIL single_start: got T+%0d, required T+1", ts - ta); end
    n_tests++;
    if (tr != ta + 6) begin n_fail++; $display("FAIL single_latency: got T+%0d, required T+6", tr - ta); end
    n_tests++;
    if (rsp_id !== 2'd0 || rsp_product !== 64'h0000_0000_00FE_FF01) begin
      n_fail++;
      $display("FAIL single_rsp: got id=%0d prod=%h, required 0 0000000000feff01", rsp_id, rsp_product);
    end
    n_tests++;
    if (mult_a !== 32'h0000_00FF || mult_b !== 32'h0000_FFFF) begin
      n_fail++;
      $display("FAIL single_operands: got a=%h b=%h, required 000000ff 0000ffff", mult_a, mult_b);
    end
    @(posedge clk); #2;
    n_tests++;
    if (rsp_valid !== 1'b0 || arb_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: got vld=%b busy=%b, required 0 0", rsp_valid, arb_busy);
    end
  endtask

  task automatic test_full_width();
    int ta, ts, tr;
    issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8, ta, ts, tr);
    n_tests++;
    if (ta < 0 || tr != ta + 11) begin
      n_fail++;
      $display("FAIL full_latency: got acc=%0d rsp=%0d, required rsp=acc+11", ta, tr);
    end
    n_tests++;
    if (rsp_id !== 2'd2 || rsp_product !== 64'hFFFF_FFFE_0000_0001) begin
      n_fail++;
      $display("FAIL full_rsp: got id=%0d prod=%h, required 2 fffffffe00000001", rsp_id, rsp_product);
    end
    wait_idle("full");
  endtask

  task automatic test_round_robin();
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    int ord[5]     = '{-1, -1, -1, -1, -1};
    int n_g = 0;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(2'(i), 32'(i + 1), 32'h10);
    for (int i = 0; i < 5; i++) push_exp(2'(exp_ord[i]), 32'(exp_ord[i] + 1), 32'h10);
    mult_lat = 4; rsp_ready = 1'b1;
    @(posedge clk); #1 req_valid = 4'hF;
    for (int c = 0; c < 150 && n_g < 5; c++) begin
      #1;
      if (req_ready != 0) begin
        for (int j = 0; j < 4; j++) if (req_ready[j]) ord[n_g] = j;
        n_g++;
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (ord[i] != exp_ord[i]) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got %0d, required %0d", i, ord[i], exp_ord[i]);
      end
    end
    wait_idle("rr");
  endtask

  task automatic test_backpressure();
    logic got = 1'b0;
    logic seen = 1'b0;
    logic [63:0] exp3;
    mult_lat = 3; rsp_ready = 1'b0;
    set_req(2'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    set_req(2'd1, 32'h0000_1000, 32'h0000_0003);
    exp3 = 64'(32'h1234_5678) * 64'(32'h9ABC_DEF0);
    @(posedge clk); #1 req_valid = 4'b1000;
    push_exp(2'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready[3]) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL bp_accept3: got none, required req_ready[3]"); end
    @(posedge clk); #1 req_valid = 4'b0010;
    push_exp(2'd1, 32'h0000_1000, 32'h0000_0003);
    for (int c = 0; c < 40; c++) begin
      #1;
      if (rsp_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL bp_rsp: got no rsp_valid, required response"); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #2;
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_product !== exp3 || req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got vld=%b id=%0d prod=%h rdy=%b, required 1 3 %h 0000",
                 c, rsp_valid, rsp_id, rsp_product, req_ready, exp3);
      end
    end
    @(posedge clk); #1 rsp_ready = 1'b1; #1;
    n_tests++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL bp_same_cycle: got rdy=%b, required 0000", req_ready);
    end
    @(posedge clk); #2;
    n_tests++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_next_grant: got rdy=%b, required 0010", req_ready);
    end
    @(posedge clk); #1 req_valid = '0;
    wait_idle("bp");
  endtask

  task automatic test_reset_mid_run();
    logic got = 1'b0;
    logic ghost = 1'b0;
    int ta, ts, tr;
    mult_lat = 8; rsp_ready = 1'b1;
    set_req(2'd0, 32'h5, 32'h7);
    @(posedge clk); #1 req_valid = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready[0]) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1 req_valid = '0; #1;
    n_tests++;
    if (!got || mult_start !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_start: got accept=%b start=%b, required 1 1", got, mult_start);
    end
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b1; #1;
    n_tests++;
    if ({req_ready, rsp_valid, rsp_id, rsp_product, mult_start, mult_a, mult_b, arb_busy} !== '0) begin
      n_fail++;
      $display("FAIL rst_outputs: got rdy=%b vld=%b start=%b a=%h b=%h busy=%b, required all 0",
               req_ready, rsp_valid, mult_start, mult_a, mult_b, arb_busy);
    end
    @(posedge clk); #1 reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #2;
      if (rsp_valid || arb_busy) ghost = 1'b1;
    end
    n_tests++;
    if (ghost) begin n_fail++; $display("FAIL rst_ghost: got activity after reset, required idle"); end
    issue(2'd3, 32'hDEAD_BEEF, 32'h2, 6, ta, ts, tr);
    n_tests++;
    if (ta < 0 || tr != ta + 9 || rsp_id !== 2'd3) begin
      n_fail++;
      $display("FAIL rst_recover: got acc=%0d rsp=%0d id=%0d, required rsp=acc+9 id=3", ta, tr, rsp_id);
    end
    wait_idle("rst");
  endtask

  task automatic test_wrap();
    int g0 = -1, g1 = -1, n_g = 0;
    logic [3:0] gm;
    mult_lat = 3; rsp_ready = 1'b1;
    set_req(2'd0, 32'd7, 32'd9);
    set_req(2'd3, 32'd11, 32'd13);
    push_exp(2'd0, 32'd7, 32'd9);
    push_exp(2'd3, 32'd11, 32'd13);
    @(posedge clk); #1 req_valid = 4'b1001;
    for (int c = 0; c < 60 && n_g < 2; c++) begin
      #1;
      gm = req_ready;
      if (gm != 0) begin
        for (int j = 0; j < 4; j++) if (gm[j]) begin if (n_g == 0) g0 = j; else g1 = j; end
        n_g++;
      end
      @(posedge clk); #1;
      req_valid = req_valid & ~gm;
    end
    req_valid = '0;
    n_tests++;
    if (g0 != 0 || g1 != 3) begin
      n_fail++;
      $display("FAIL wrap_order: got %0d,%0d, required 0,3", g0, g1);
    end
    wait_idle("wrap");
  endtask

  initial begin
    fork
      sb_monitor();
    join_none
    test_reset();
    test_single();
    test_full_width();
    test_round_robin();
    test_backpressure();
    test_reset_mid_run();
    test_wrap();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_empty: got %0d outstanding, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
